mmio_data_fifo: RTL
===================

Name: mmio_data_fifo

Overview:
- Circular-buffer FIFO between the AFU MMIO write decode (producer) and the MMIO read-response path (consumer).
- Host MMIO writes to the data register push 64-bit words. Host MMIO reads of the same register pop them.
- Exposes registered full/empty/count and sticky error flags so the AFU can map a status CSR.
- Replaces the fixed delay-line buffer with a handshake-controlled buffer.

Parameters:
- WIDTH, 64: data word width in bits.
- DEPTH, 8: number of entries. Must be a power of 2 and >= 2.
- CW, $clog2(DEPTH)+1: width of count (derived, localparam).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- push  input  1  write strobe, one word per cycle while high
- push_data  input  WIDTH  word to enqueue
- pop  input  1  read strobe
- pop_data  output  WIDTH  dequeued word, registered
- pop_valid  output  1  pop_data holds a real word this cycle
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  CW  current occupancy, 0..DEPTH
- overflow  output  1  sticky: push dropped while full
- underflow  output  1  sticky: pop while empty
- clr_err  input  1  clears overflow and underflow

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values: pop_data=0, pop_valid=0, count=0, empty=1, full=0, overflow=0, underflow=0. Read/write pointers are 0. Storage array contents are not reset.
- Reset asserted mid-operation discards all contents immediately. The first push after reset release is stored at entry 0.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- full, empty and count are registered; they reflect every push/pop of the previous cycle.
- Push accepted (push && !full):
  - push_data is written to mem[wr_ptr]; wr_ptr increments.
- Push while full:
  - The word is dropped; overflow <= 1; pointers unchanged.
  - Exception: a simultaneous pop makes the push legal (see below).
- Pop accepted (pop && !empty):
  - Next cycle, pop_data = mem[rd_ptr] and pop_valid = 1; rd_ptr increments. Latency is 1 cycle.
- Pop while empty:
  - Next cycle, pop_valid = 0 and pop_data = 0; underflow <= 1.
  - The MMIO path therefore returns 0 for a read of an empty FIFO.
- No-pop cycle: pop_valid = 0 and pop_data holds its last value.
- Push and pop together, not empty (including full):
  - Both are accepted and count is unchanged.
  - When full, the pop frees a slot, so the push is accepted with no overflow.
- Push and pop together while empty:
  - No fall-through: the pop is an underflow and pop_data = 0 next cycle.
  - The push is accepted and count becomes 1.
- Count update: count_next = count + push_acc - pop_acc.
- Flag update:
  - full_next = (count_next == DEPTH).
  - empty_next = (count_next == 0).
- Error flags:
  - Once set, each flag holds until clr_err.
  - clr_err in the same cycle as a new error event: set wins, and the flag stays 1.

Optional Feature:
- Macro: MMIO_DATA_FIFO_STATS_EN.
- When defined:
  - Adds output drop_cnt[15:0]: counts dropped pushes plus empty pops.
  - The counter saturates at 16'hFFFF and resets to 0.
  - clr_err also clears drop_cnt, unless an error event occurs in the same cycle, in which case drop_cnt = 1.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Reset, then push 8'h01..8'h08 (DEPTH=8) on consecutive cycles -> count=8, full=1 one cycle after the 8th push, overflow=0.
2. While full, push 64'hDEAD -> dropped, overflow=1, count stays 8. Then pop 8 times -> pop_data = 1..8 in order, each 1 cycle after its pop, empty=1 after the last.
3. Fill to 8, then push 64'hAA and pop in the same cycle -> pop returns 1, count stays 8, overflow=0. Draining returns 2..8, then 64'hAA (pointer wrap verified).
4. Empty FIFO: pop and push 64'h55 together -> next cycle pop_valid=0, pop_data=0, underflow=1, count=1. The following pop returns 64'h55.
5. With both error flags set: assert clr_err alone -> both flags 0 next cycle. Then clr_err together with a pop on empty -> underflow stays 1.
6. Assert rst mid-stream with count=5 -> all outputs at reset values immediately. After release, push 64'h77 then pop -> returns 64'h77. With MMIO_DATA_FIFO_STATS_EN defined, drop_cnt is also 0 after reset.

Source files
------------

// File: rtl/mmio_data_fifo.sv
// mmio_data_fifo: circular-buffer FIFO between the AFU MMIO write decode
// (producer) and the MMIO read-response path (consumer).
//   - push writes one WIDTH-bit word per cycle; pop returns a word one cycle later.
//   - full/empty/count are registered; overflow/underflow are sticky until clr_err.
//   - Optional build macro MMIO_DATA_FIFO_STATS_EN adds drop_cnt[15:0], a
//     saturating count of dropped pushes plus empty pops.
// DEPTH must be a power of two and >= 2 so that pointers wrap naturally.
module mmio_data_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     pop_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
`ifdef MMIO_DATA_FIFO_STATS_EN
  output logic [15:0]              drop_cnt,
`endif
  input  logic                     clr_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Storage is intentionally left unreset.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          push_acc;
  logic          pop_acc;
  logic          ovf_evt;
  logic          unf_evt;
  logic [CW-1:0] count_next;

  // Handshake decode: a pop on a full FIFO frees the slot the push needs.
  always_comb begin
    pop_acc    = pop && !empty;
    push_acc   = push && (!full || pop_acc);
    ovf_evt    = push && !push_acc;
    unf_evt    = pop && empty;
    count_next = count + CW'(push_acc) - CW'(pop_acc);
  end

  // Array write port.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      full  <= (count_next == DEPTH_C);
      empty <= (count_next == '0);
    end
  end

  // Read-response register: empty pops return zero, idle cycles hold the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_data  <= '0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= pop_acc;
      if (pop_acc) begin
        pop_data <= mem[rd_ptr];
      end else if (pop) begin
        pop_data <= '0;
      end
    end
  end

  // Sticky error flags; a new event in the clr_err cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (unf_evt) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef MMIO_DATA_FIFO_STATS_EN
  // Saturating drop counter; full and empty are exclusive, so at most one
  // drop event can occur per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (clr_err) begin
      drop_cnt <= (ovf_evt || unf_evt) ? 16'd1 : 16'd0;
    end else if ((ovf_evt || unf_evt) && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
